// File: rtl/alu_writeback_if.sv
// alu_writeback_if: ALU-result input bus and register-file write port
// of the writeback stage, bundled with master (producer/consumer side)
// and slave (writeback stage side) views.
interface alu_writeback_if #(
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_result;
  logic              in_carry;
  logic [1:0]        in_size;
  logic [REG_AW-1:0] in_dest;
  logic [63:0]       in_old;
  logic              wb_valid;
  logic              wb_ready;
  logic [REG_AW-1:0] wb_addr;
  logic [63:0]       wb_data;
  logic [2:0]        flags;

  modport master (
    output in_valid, in_result, in_carry, in_size, in_dest, in_old, wb_ready,
    input  in_ready, wb_valid, wb_addr, wb_data, flags
  );

  modport slave (
    input  in_valid, in_result, in_carry, in_size, in_dest, in_old, wb_ready,
    output in_ready, wb_valid, wb_addr, wb_data, flags
  );
endinterface

// File: rtl/alu_writeback.sv
// alu_writeback: merges sized ALU results into the old destination value,
// queues them in a DEPTH-entry FIFO and drives the register-file write port.
// Optional feature macro ALU_WB_FLAGS_EN: per-entry Z/N/C flags and the
// committed flags register. Without it, flags is tied to zero.
module alu_writeback #(
  parameter int DEPTH  = 2,
  parameter int REG_AW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_writeback_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Partial-width results overwrite only the low field of the old value.
  function automatic logic [63:0] merge_f(input logic [1:0]  size,
                                          input logic [63:0] res,
                                          input logic [63:0] old);
    logic [63:0] m;
    case (size)
      2'd0:    m = {old[63:8],  res[7:0]};
      2'd1:    m = {old[63:16], res[15:0]};
      2'd2:    m = {old[63:32], res[31:0]};
      2'd3:    m = res;
      default: m = res;
    endcase
    return m;
  endfunction

  logic [REG_AW-1:0] addr_mem_r [DEPTH];
  logic [63:0]       data_mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              in_ready_s;
  logic              wb_valid_s;
  logic              push_s;
  logic              pop_s;
  logic [63:0]       merge_s;

  // Ready depends only on stored occupancy, so a pop never frees a slot
  // for a push in the same cycle.
  assign in_ready_s   = (count_r < DEPTH_C);
  assign wb_valid_s   = (count_r != {CW{1'b0}});
  assign push_s       = bus.in_valid && in_ready_s;
  assign pop_s        = wb_valid_s && bus.wb_ready;
  assign merge_s      = merge_f(bus.in_size, bus.in_result, bus.in_old);

  assign bus.in_ready = in_ready_s;
  assign bus.wb_valid = wb_valid_s;
  assign bus.wb_addr  = addr_mem_r[rd_ptr_r];
  assign bus.wb_data  = data_mem_r[rd_ptr_r];

  // FIFO storage: cleared on reset, written at the tail on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= {REG_AW{1'b0}};
        data_mem_r[i] <= 64'h0;
      end
    end else if (push_s) begin
      addr_mem_r[wr_ptr_r] <= bus.in_dest;
      data_mem_r[wr_ptr_r] <= merge_s;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef ALU_WB_FLAGS_EN
  // Z/N over the sized field only; C passes straight from the ALU.
  function automatic logic [2:0] flags_f(input logic [1:0]  size,
                                         input logic [63:0] res,
                                         input logic        carry);
    logic z;
    logic n;
    case (size)
      2'd0:    begin z = (res[7:0]  == 8'h0);  n = res[7];  end
      2'd1:    begin z = (res[15:0] == 16'h0); n = res[15]; end
      2'd2:    begin z = (res[31:0] == 32'h0); n = res[31]; end
      2'd3:    begin z = (res == 64'h0);       n = res[63]; end
      default: begin z = (res == 64'h0);       n = res[63]; end
    endcase
    return {z, n, carry};
  endfunction

  logic [2:0] flag_mem_r [DEPTH];
  logic [2:0] flags_r;

  // Per-entry flags captured at accept alongside the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        flag_mem_r[i] <= 3'b000;
      end
    end else if (push_s) begin
      flag_mem_r[wr_ptr_r] <= flags_f(bus.in_size, bus.in_result, bus.in_carry);
    end
  end

  // Architectural flags commit when the head entry is written back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= 3'b000;
    end else if (pop_s) begin
      flags_r <= flag_mem_r[rd_ptr_r];
    end else begin
      flags_r <= flags_r;
    end
  end

  assign bus.flags = flags_r;
`else
  logic unused_carry_s;
  assign unused_carry_s = bus.in_carry;
  assign bus.flags      = 3'b000;
`endif
endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback stage directly downstream of the combinational ALU arithmetic unit. It accepts the ALU's 64-bit result and carry together with operand size and destination register. It merges partial-width results into the old destination value, queues the merged writes in a small FIFO, and drives the register-file write port with a valid/ready handshake. It also maintains the architectural Z/N/C flag register, updated at commit.

## Interface
- `DEPTH`, 2: FIFO entries (power of two, ≥2)
- `REG_AW`, 5: register address width

- `clk` in 1: clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `in_valid` in 1: ALU result valid
- `in_ready` out 1: stage can accept
- `in_result` in 64: ALU result
- `in_carry` in 1: ALU carry
- `in_size` in 2: operand size (0=BITS_8, 1=BITS_16, 2=BITS_32, 3=BITS_64)
- `in_dest` in REG_AW: destination register
- `in_old` in 64: current destination register contents
- `wb_valid` out 1: write pending
- `wb_ready` in 1: register file accepts write
- `wb_addr` out REG_AW: write address
- `wb_data` out 64: merged write data
- `flags` out 3: {Z, N, C}, committed flags

## Operation
- Accept when `in_valid && in_ready`. Merge happens at accept:
  - size 0: {old[63:8], res[7:0]}
  - size 1: {old[63:16], res[15:0]}
  - size 2: {old[63:32], res[31:0]}
  - size 3: res
- Per-entry flags are computed at accept, over the sized field only:
  - Z = field == 0
  - N = field MSB (bit 7/15/31/63)
  - C = `in_carry`
- FIFO stores {addr, data, Z, N, C}. Head drives `wb_addr`/`wb_data`.
- Occupancy counter runs 0..DEPTH. Read and write pointers wrap modulo DEPTH.
- `in_ready` = count < DEPTH. It is a registered-state function with no combinational path from `wb_ready`. When full, a simultaneous pop does not enable a push that cycle.
- `wb_valid` = count != 0.
- Pop on `wb_valid && wb_ready`. At pop, the head's flags load into `flags`.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Push when empty: the entry is visible the next cycle. There is no same-cycle bypass.
- Entries are not reordered or coalesced. Back-to-back writes to the same register are emitted in order.
- `in_old` is sampled only at accept. Hazards on stale `in_old` are the issue stage's responsibility.

## Timing
- Latency: accept at edge N → `wb_valid` high after edge N, held until a pop.
- Throughput: 1 write/cycle when `wb_ready` is held high.
- `wb_addr`/`wb_data` stay stable while `wb_valid && !wb_ready`.
- `flags` update on the edge of the pop cycle and are visible the next cycle.
- Reset values (async assert, synchronous-release-safe):
  - count = 0, pointers = 0
  - `wb_valid` = 0, `in_ready` = 1
  - `wb_addr` = 0, `wb_data` = 0
  - `flags` = 3'b000
  - FIFO storage cleared
- Reset mid-operation discards all queued entries. Nothing is written after deassertion until a new accept.

## Configuration
- `ALU_WB_FLAGS_EN` defined: per-entry flag computation, flag FIFO fields and the `flags` register are present, as described above.
- Not defined: no flag storage or logic. `flags` is tied to 3'b000. Data path and handshake are unchanged.

## Test plan
- Size merge: old=64'hFFFF_FFFF_FFFF_FFFF, res=64'h12, size 0 → `wb_data` = 64'hFFFF_FFFF_FFFF_FF12. Size 2 with res=64'h0 → 64'hFFFF_FFFF_0000_0000, and after pop `flags` = Z=1,N=0.
- Flags: size 1, res=16'h8000, carry=1 → after pop `flags` = {0,1,1}. Size 3, res=0, carry=0 → {1,0,0}. With `ALU_WB_FLAGS_EN` undefined → always 0.
- Backpressure: `wb_ready`=0, push 3 entries → `in_ready` drops after 2 accepts. The third accept happens only on the cycle after the first pop. Order is addr 1,2,3.
- Streaming: `wb_ready`=1, push every cycle for 10 cycles → 10 writes, 1-cycle latency, `in_ready` never drops.
- Pointer wrap: push/pop 2·DEPTH+1 entries in mixed patterns → data in order, count returns to 0.
- Reset: assert `rst_n`=0 with 2 queued entries mid-cycle → `wb_valid`=0 and `flags`=0 immediately. After release, no write appears until a new push.
